apb_request_arbiter: RTL and testbench

- Shares the single APB master between N_REQ on-chip requesters (CPU core, DMA, debug).
- Drives the processor-side bus of the APB master: start, write, sel, addr, wdata, wait_cycles.
- Returns rdata and a completion or error strobe to the granted requester.
- Round-robin fairness; a per-transfer watchdog aborts transfers whose slave never asserts ready.

---
 rtl/apb_arb_pkg.sv | 25 ++
 rtl/rr_pick.sv | 32 +++
 rtl/apb_request_arbiter.sv | 163 ++++++++++++++++
 tb/tb_apb_request_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types, field widths and helpers for the APB request arbiter.
package apb_arb_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int SEL_W  = 2;
    localparam int WAIT_W = 8;
    localparam int CNT_W  = 8;

    localparam logic [SEL_W-1:0] SEL_NONE = 2'b00;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    // Bits needed to index n requesters; never less than one bit.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after the pointer, wrapping.
module rr_pick
    import apb_arb_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = idxWidth(N)
)(
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          valid_o,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    // Walk the request vector starting at the pointer and keep the first hit.
    always_comb begin
        int cand;
        cand    = 0;
        valid_o = 1'b0;
        gnt_o   = '0;
        idx_o   = '0;
        for (int i = 0; i < N; i++) begin
            cand = (int'(ptr_i) + i) % N;
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/apb_request_arbiter.sv
// Round-robin arbiter sharing one APB master between N_REQ requesters,
// with a per-transfer watchdog that aborts transfers the slave never finishes.
module apb_request_arbiter
    import apb_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
)(
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          req_write,
    input  logic [SEL_W*N_REQ-1:0]    req_sel,
    input  logic [ADDR_W*N_REQ-1:0]   req_addr,
    input  logic [DATA_W*N_REQ-1:0]   req_wdata,
    input  logic [WAIT_W*N_REQ-1:0]   req_wait,
    output logic [N_REQ-1:0]          done,
    output logic [N_REQ-1:0]          err,
    output logic [DATA_W-1:0]         rdata_out,
    output logic [N_REQ-1:0]          gnt,
    output logic                      pb_start,
    output logic                      pb_write,
    output logic [SEL_W-1:0]          pb_sel,
    output logic [ADDR_W-1:0]         pb_addr,
    output logic [DATA_W-1:0]         pb_wdata,
    output logic [WAIT_W-1:0]         pb_wait,
    input  logic                      pb_ready,
    input  logic [DATA_W-1:0]         pb_rdata
);

    localparam int              IW         = idxWidth(N_REQ);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [IW-1:0]   OWNER_LAST = IW'(N_REQ - 1);

    state_t              state_q, state_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [IW-1:0]       owner_q, owner_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                write_q, write_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                winValid;
    logic [N_REQ-1:0]    winGnt;
    logic [IW-1:0]       winIdx;
    logic [SEL_W-1:0]    winSel;

    rr_pick #(.N(N_REQ)) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .valid_o (winValid),
        .gnt_o   (winGnt),
        .idx_o   (winIdx)
    );

    assign winSel = req_sel[SEL_W*int'(winIdx) +: SEL_W];

    // State register and latched bus fields; reset abandons any transfer in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
            write_q <= 1'b0;
            sel_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wait_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wait_q  <= wait_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state logic: requester inputs are only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wait_d  = wait_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (winValid) begin
                    owner_d = winIdx;
                    gnt_d   = winGnt;
                    write_d = req_write[winIdx];
                    sel_d   = winSel;
                    addr_d  = req_addr[ADDR_W*int'(winIdx) +: ADDR_W];
                    wdata_d = req_wdata[DATA_W*int'(winIdx) +: DATA_W];
                    wait_d  = req_wait[WAIT_W*int'(winIdx) +: WAIT_W];
                    if (winSel == SEL_NONE) begin
                        rdata_d = '0;
                        state_d = ERR;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (pb_ready) begin
                    rdata_d = pb_rdata;
                    state_d = DONE;
                end else begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (cnt_q == CNT_LAST) begin
                        rdata_d = '0;
                        state_d = ERR;
                    end
                end
            end
            DONE, ERR: begin
                ptr_d   = (owner_q == OWNER_LAST) ? '0 : owner_q + IW'(1);
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pb_start  = (state_q == ISSUE);
    assign done      = (state_q == DONE) ? gnt_q : '0;
    assign err       = (state_q == ERR)  ? gnt_q : '0;
    assign gnt       = gnt_q;
    assign rdata_out = rdata_q;
    assign pb_write  = write_q;
    assign pb_sel    = sel_q;
    assign pb_addr   = addr_q;
    assign pb_wdata  = wdata_q;
    assign pb_wait   = wait_q;

endmodule

// File: tb/tb_apb_request_arbiter.sv
// Self-checking bench for apb_request_arbiter: table of request vectors,
// a scoreboard of expected transfers, and a small slave model driving pb_ready.
module tb_apb_request_arbiter;

    localparam int NR = 4;
    localparam int TO = 8;

    logic          clk;
    logic          reset_n;
    logic [3:0]    req;
    logic [3:0]    req_write;
    logic [7:0]    req_sel;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic [31:0]   req_wait;
    logic [3:0]    done;
    logic [3:0]    err;
    logic [7:0]    rdata_out;
    logic [3:0]    gnt;
    logic          pb_start;
    logic          pb_write;
    logic [1:0]    pb_sel;
    logic [7:0]    pb_addr;
    logic [7:0]    pb_wdata;
    logic [7:0]    pb_wait;
    logic          pb_ready;
    logic [7:0]    pb_rdata;

    apb_request_arbiter #(.N_REQ(NR), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .req_write (req_write),
        .req_sel   (req_sel),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wait  (req_wait),
        .done      (done),
        .err       (err),
        .rdata_out (rdata_out),
        .gnt       (gnt),
        .pb_start  (pb_start),
        .pb_write  (pb_write),
        .pb_sel    (pb_sel),
        .pb_addr   (pb_addr),
        .pb_wdata  (pb_wdata),
        .pb_wait   (pb_wait),
        .pb_ready  (pb_ready),
        .pb_rdata  (pb_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One request vector: which requesters ask, their fields, and the slave response.
    typedef struct {
        logic [3:0] mask;
        logic [3:0] write;
        logic [7:0] sel;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        int         delay;
    } vec_t;

    // One expected transfer in the scoreboard.
    typedef struct {
        int          winner;
        logic        badSel;
        logic        isErr;
        logic [26:0] fields;
        logic [7:0]  slaveRdata;
        logic [7:0]  expRdata;
        int          delay;
        int          latency;
    } exp_t;

    exp_t  sbQ[$];
    vec_t  vecs[8];
    int    nCompared;
    int    nMismatched;
    int    mdlPtr;
    int    sinceFree;
    int    sinceStart;
    int    waitLeft;
    logic  inWait;
    logic  gapPending;
    logic  holdReqs;
    logic  scrambled;
    logic [7:0] curRdata;

    task automatic compare(input string name, input logic [63:0] act, input logic [63:0] expv);
        nCompared++;
        if (act !== expv) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic logic [3:0] oneHot(input int w);
        logic [3:0] base;
        base = 4'b0001;
        return base << w;
    endfunction

    // Round-robin reference: first requester at or after p, wrapping.
    function automatic int rrWinner(input logic [3:0] m, input int p);
        int j;
        for (int i = 0; i < NR; i++) begin
            j = (p + i) % NR;
            if (m[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [26:0] fieldsFor(input vec_t v, input int w);
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] wt;
        a  = v.addr + 8'(w);
        d  = v.wdata + 8'(w);
        wt = 8'(v.delay) + 8'(w * 16);
        return {v.write[w], v.sel[2*w +: 2], a, d, wt};
    endfunction

    function automatic logic [26:0] pbFields();
        return {pb_write, pb_sel, pb_addr, pb_wdata, pb_wait};
    endfunction

    function automatic logic [47:0] allOutputs();
        return {done, err, rdata_out, gnt, pb_start, pb_write, pb_sel, pb_addr, pb_wdata, pb_wait};
    endfunction

    // Build the expected result of requester w being served from vector v.
    task automatic pushExpected(input vec_t v, input int w);
        exp_t e;
        e.winner     = w;
        e.fields     = fieldsFor(v, w);
        e.badSel     = (v.sel[2*w +: 2] == 2'b00);
        e.slaveRdata = v.rdata + 8'(w);
        e.delay      = v.delay;
        if (e.badSel) begin
            e.isErr    = 1'b1;
            e.expRdata = 8'h00;
            e.latency  = 0;
        end else if (v.delay < TO) begin
            e.isErr    = 1'b0;
            e.expRdata = e.slaveRdata;
            e.latency  = v.delay + 2;
        end else begin
            e.isErr    = 1'b1;
            e.expRdata = 8'h00;
            e.latency  = TO + 1;
        end
        sbQ.push_back(e);
    endtask

    task automatic applyStimulus(input vec_t v);
        for (int r = 0; r < NR; r++) begin
            req_write[r]         = v.write[r];
            req_sel[2*r +: 2]    = v.sel[2*r +: 2];
            req_addr[8*r +: 8]   = v.addr + 8'(r);
            req_wdata[8*r +: 8]  = v.wdata + 8'(r);
            req_wait[8*r +: 8]   = 8'(v.delay) + 8'(r * 16);
        end
        scrambled = 1'b0;
        req       = v.mask;
        sinceFree = 1;
    endtask

    // Per-cycle monitor and slave model, called at each falling edge.
    task automatic checkOutput();
        exp_t e;
        sinceFree++;
        if (inWait) sinceStart++;
        if (gapPending) begin
            compare("idle_gap", 64'({gnt, done, err, pb_start}), 64'(0));
            gapPending = 1'b0;
        end
        if (pb_start) begin
            if (sbQ.size() == 0) begin
                compare("spurious_start", 64'(pb_start), 64'(0));
            end else begin
                e = sbQ[0];
                if (e.badSel) compare("badsel_no_start", 64'(pb_start), 64'(0));
                compare("start_gnt", 64'(gnt), 64'(oneHot(e.winner)));
                compare("start_fields", 64'(pbFields()), 64'(e.fields));
                compare("grant_latency", 64'(sinceFree), 64'(2));
                inWait     = 1'b1;
                sinceStart = 0;
                waitLeft   = e.delay;
                curRdata   = e.slaveRdata;
                pb_ready   = 1'b0;
                pb_rdata   = ~e.slaveRdata;
                req_addr   = ~req_addr;
                req_wdata  = ~req_wdata;
                scrambled  = 1'b1;
            end
        end else if ((|done) || (|err)) begin
            if (sbQ.size() == 0) begin
                compare("spurious_strobe", 64'({done, err}), 64'(0));
            end else begin
                e = sbQ.pop_front();
                compare("strobe", 64'({done, err}),
                        e.isErr ? 64'({4'b0000, oneHot(e.winner)}) : 64'({oneHot(e.winner), 4'b0000}));
                compare("strobe_gnt", 64'(gnt), 64'(oneHot(e.winner)));
                compare("end_fields", 64'(pbFields()), 64'(e.fields));
                compare("rdata_out", 64'(rdata_out), 64'(e.expRdata));
                if (e.badSel) compare("badsel_latency", 64'(sinceFree), 64'(2));
                else          compare("xfer_latency", 64'(sinceStart), 64'(e.latency));
                if (!holdReqs)            req[e.winner] = 1'b0;
                else if (sbQ.size() == 0) req = 4'b0000;
            end
            if (scrambled) begin
                req_addr  = ~req_addr;
                req_wdata = ~req_wdata;
                scrambled = 1'b0;
            end
            inWait     = 1'b0;
            pb_ready   = 1'b0;
            gapPending = 1'b1;
            sinceFree  = 0;
        end else if (inWait) begin
            if (waitLeft == 0) begin
                pb_ready = 1'b1;
                pb_rdata = curRdata;
            end else begin
                waitLeft--;
                pb_ready = 1'b0;
            end
        end
    endtask

    // Step until every expected transfer has finished and its IDLE gap was seen.
    task automatic waitDrain(input int tag);
        int cyc;
        cyc = 0;
        while ((sbQ.size() != 0 || gapPending) && cyc < 400) begin
            @(negedge clk);
            checkOutput();
            cyc++;
        end
        if (sbQ.size() != 0 || gapPending) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL drain_timeout vector %0d: %0d transfers still pending, required 0", tag, sbQ.size());
            sbQ.delete();
            gapPending = 1'b0;
            inWait     = 1'b0;
            pb_ready   = 1'b0;
            req        = 4'b0000;
        end
    endtask

    task automatic runVector(input vec_t v, input int tag);
        logic [3:0] rem;
        int p;
        int w;
        rem = v.mask;
        p   = mdlPtr;
        while (rem != 4'b0000) begin
            w = rrWinner(rem, p);
            pushExpected(v, w);
            rem[w] = 1'b0;
            p = (w + 1) % NR;
        end
        mdlPtr = p;
        applyStimulus(v);
        waitDrain(tag);
    endtask

    initial begin
        vec_t vc;
        vec_t vr;
        vec_t vf;
        int   cyc;
        logic strobeSeen;
        int   order[5];

        nCompared   = 0;
        nMismatched = 0;
        mdlPtr      = 0;
        sinceFree   = 0;
        sinceStart  = 0;
        waitLeft    = 0;
        inWait      = 1'b0;
        gapPending  = 1'b0;
        holdReqs    = 1'b0;
        scrambled   = 1'b0;
        curRdata    = 8'h00;
        reset_n     = 1'b0;
        req         = '0;
        req_write   = '0;
        req_sel     = '0;
        req_addr    = '0;
        req_wdata   = '0;
        req_wait    = '0;
        pb_ready    = 1'b0;
        pb_rdata    = '0;

        //          mask     write    sel    addr   wdata  rdata  delay
        vecs[0] = '{4'b0001, 4'b0001, 8'h01, 8'h10, 8'hA5, 8'h3E, 1};
        vecs[1] = '{4'b0100, 4'b0000, 8'h20, 8'h31, 8'h00, 8'h5A, 0};
        vecs[2] = '{4'b0110, 4'b0000, 8'h10, 8'h40, 8'h22, 8'h70, 0};
        vecs[3] = '{4'b1000, 4'b1000, 8'hC0, 8'h50, 8'h33, 8'h99, 20};
        vecs[4] = '{4'b1000, 4'b0000, 8'hC0, 8'h60, 8'h44, 8'hAB, 7};
        vecs[5] = '{4'b0010, 4'b0010, 8'h04, 8'h70, 8'h55, 8'hCD, 8};
        vecs[6] = '{4'b1011, 4'b1010, 8'hFF, 8'h90, 8'h66, 8'h12, 3};
        vecs[7] = '{4'b0101, 4'b0001, 8'h11, 8'hA0, 8'h77, 8'h34, 2};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        compare("reset_outputs", 64'(allOutputs()), 64'(0));
        reset_n = 1'b1;
        @(negedge clk);
        compare("idle_after_reset", 64'(allOutputs()), 64'(0));

        // Contention: all four held high from pointer 0 -> 0,1,2,3,0
        vc = '{4'b1111, 4'b0101, 8'h6D, 8'h80, 8'h11, 8'hC0, 0};
        order = '{0, 1, 2, 3, 0};
        holdReqs = 1'b1;
        for (int k = 0; k < 5; k++) pushExpected(vc, order[k]);
        applyStimulus(vc);
        waitDrain(100);
        holdReqs = 1'b0;
        req      = 4'b0000;
        mdlPtr   = 1;

        // Table of request vectors
        for (int i = 0; i < 8; i++) begin
            runVector(vecs[i], i);
        end

        // Asynchronous reset in the middle of WAIT
        vr = '{4'b0001, 4'b0001, 8'h01, 8'hE0, 8'h88, 8'h55, 20};
        pushExpected(vr, 0);
        applyStimulus(vr);
        cyc = 0;
        while (!(inWait && sinceStart >= 3) && cyc < 50) begin
            @(negedge clk);
            checkOutput();
            cyc++;
        end
        #2 reset_n = 1'b0;
        #1 compare("async_reset_outputs", 64'(allOutputs()), 64'(0));
        sbQ.delete();
        req        = 4'b0000;
        pb_ready   = 1'b0;
        inWait     = 1'b0;
        gapPending = 1'b0;
        scrambled  = 1'b0;
        mdlPtr     = 0;
        @(negedge clk);
        reset_n    = 1'b1;
        strobeSeen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            strobeSeen = strobeSeen | (|{done, err, pb_start});
        end
        compare("no_strobe_after_reset", 64'(strobeSeen), 64'(0));

        // Fresh requests after reset start from requester 0
        vf = '{4'b1110, 4'b0100, 8'h9C, 8'hB0, 8'h99, 8'h61, 1};
        runVector(vf, 200);
        vf = '{4'b1111, 4'b0011, 8'hE7, 8'hC0, 8'hAA, 8'h07, 0};
        mdlPtr = 0;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        runVector(vf, 201);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
